mem_port_arbiter: RTL and testbench

Shares the core's single unified memory port between the instruction fetch stage (I port) and the memory stage load/store path (D port). It serializes the two requesters onto one downstream handshake with one outstanding transaction at a time. It generates byte enables and write-data lane alignment from the store's funct3 and address, and sign- or zero-extends load data. It also produces the fetch and memory stall signals consumed by the hazard logic.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_lane.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_I_WAIT,
    ST_D_WAIT
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_lane.sv
// Byte-lane logic: byte enables, store replication, load extension.
module mem_lane
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic       is_b;
  logic       is_h;
  logic       sext;
  logic [1:0] off;
  logic [7:0] b_sel;
  logic [15:0] h_sel;

  assign is_b = (funct3[1:0] == F3_B[1:0]);
  assign is_h = (funct3[1:0] == F3_H[1:0]);
  assign sext = !funct3[2];

  always_comb begin
    be        = 4'b0000;
    wdata_al  = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    off       = 2'b00;
    b_sel     = '0;
    h_sel     = '0;
    unique case (1'b1)
      is_b: begin
        off       = addr_lo;
        be        = 4'b0001 << off;
        wdata_al  = {4{wdata[7:0]}};
        b_sel     = rdata[{off, 3'b000} +: 8];
        rdata_ext = {{24{sext & b_sel[7]}}, b_sel};
      end
      is_h: begin
        // odd halfword address falls back to the containing half
        off       = {addr_lo[1], 1'b0};
        misalign  = addr_lo[0];
        be        = 4'b0011 << off;
        wdata_al  = {2{wdata[15:0]}};
        h_sel     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = {{16{sext & h_sel[15]}}, h_sel};
      end
      default: begin
        misalign  = (addr_lo != 2'b00);
        be        = 4'b1111;
        wdata_al  = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter onto one memory port, one transaction in flight.
// Optional starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_misalign,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        stall_f,
  output logic        stall_m
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT out of range 1..15");
  end

  arb_state_e state_q, state_d;

  logic        idle;
  logic        i_first;
  logic        sel_d;
  logic        own;
  logic [31:0] addr_sel;
  mem_req_t    req;
  logic        req_raw;
  logic        fire;
  logic        d_grant;
  logic        i_grant;
  logic        i_fin;
  logic        d_fin;
  logic        d_st_done;
  logic        mis_raw;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] cnt_q, cnt_d;
  assign i_first = i_req && (cnt_q >= LIMIT);
`else
  assign i_first = 1'b0;
`endif

  mem_lane u_lane (
    .funct3    (d_funct3),
    .addr_lo   (d_addr[1:0]),
    .wdata     (d_wdata),
    .rdata     (m_rdata),
    .be        (lane_be),
    .wdata_al  (lane_wdata),
    .rdata_ext (lane_rdata),
    .misalign  (mis_raw)
  );

  always_comb begin
    idle  = (state_q == ST_IDLE);
    sel_d = d_req && !i_first;
    if (idle) own = sel_d ? OWN_D : OWN_I;
    else      own = (state_q == ST_D_WAIT) ? OWN_D : OWN_I;
    addr_sel  = (own == OWN_D) ? d_addr : i_addr;
    req.addr  = addr_sel & ~32'h3;
    req.wdata = (own == OWN_D) ? lane_wdata : '0;
    req.be    = (own == OWN_D) ? lane_be : 4'hF;
    req.we    = (own == OWN_D) && d_we;
    req_raw   = idle && (i_req || d_req);
    fire      = req_raw && m_ready;
    d_grant   = fire && (own == OWN_D);
    i_grant   = fire && (own == OWN_I);
    d_st_done = d_grant && d_we;
    i_fin     = (state_q == ST_I_WAIT) && m_rvalid;
    d_fin     = (state_q == ST_D_WAIT) && m_rvalid;

    state_d = state_q;
    unique case (1'b1)
      d_grant && !d_we: state_d = ST_D_WAIT;
      i_grant:          state_d = ST_I_WAIT;
      i_fin || d_fin:   state_d = ST_IDLE;
      default:          state_d = state_q;
    endcase

`ifdef ARB_STARVE_GUARD_EN
    cnt_d = cnt_q;
    if (!i_req || i_grant)
      cnt_d = 4'd0;
    else if (d_grant && cnt_q != 4'hF)
      cnt_d = cnt_q + 4'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
`ifdef ARB_STARVE_GUARD_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_STARVE_GUARD_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // everything is forced quiet while reset is held
  assign m_req      = rst_n && req_raw;
  assign m_we       = rst_n && req.we;
  assign m_addr     = rst_n ? req.addr : '0;
  assign m_wdata    = rst_n ? req.wdata : '0;
  assign m_be       = rst_n ? req.be : '0;
  assign i_rvalid   = rst_n && i_fin;
  assign i_rdata    = rst_n ? m_rdata : '0;
  assign d_done     = rst_n && (d_st_done || d_fin);
  assign d_rdata    = rst_n ? lane_rdata : '0;
  assign d_misalign = rst_n && d_grant && mis_raw;
  assign stall_f    = rst_n && i_req && !i_fin;
  assign stall_m    = rst_n && d_req && !(d_st_done || d_fin);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, random D traffic
// against a byte-lane model, and hand sequences for arbitration and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_misalign;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        stall_f;
  logic        stall_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned LIM = 2;
`else
  localparam int unsigned LIM = 4;
`endif

  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_done(d_done), .d_rdata(d_rdata),
    .d_misalign(d_misalign),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        mis;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Byte-lane reference: access size, aligned offset, lane arithmetic.
  function automatic void model(input logic [2:0] f3, input logic [1:0] lo,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic [3:0] be, output logic [31:0] wa,
                                output logic [31:0] ra, output logic mis);
    int size;
    int off;
    longint v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(lo) - (int'(lo) % size);
    mis  = (int'(lo) % size) != 0;
    be   = '0;
    wa   = '0;
    for (int k = 0; k < 4; k++) begin
      if (k >= off && k < off + size) be[k] = 1'b1;
      wa[8*k +: 8] = wd[8*(k % size) +: 8];
    end
    v = longint'(rd >> (8 * off));
    if (size < 4) begin
      v = v & ((64'sd1 << (8 * size)) - 1);
      if (!f3[2] && v[8*size-1]) v = v - (64'sd1 << (8 * size));
    end
    ra = v[31:0];
  endfunction

  task automatic do_d(input string nm, input logic [2:0] f3, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input int stalls, input int lat,
                      input logic [3:0] ebe, input logic [31:0] ewd,
                      input logic [31:0] erd, input logic emis);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr;
    d_wdata = wd; d_funct3 = f3; m_ready = 1'b0;
    for (int s = 0; s < stalls; s++) begin
      #1;
      chk({nm, " hold m_req"}, 32'(m_req), 32'd1);
      chk({nm, " hold m_addr"}, m_addr, addr & ~32'h3);
      chk({nm, " hold d_done"}, 32'(d_done), 32'd0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    #1;
    chk({nm, " m_addr"}, m_addr, addr & ~32'h3);
    chk({nm, " m_we"}, 32'(m_we), 32'(we));
    if (we) begin
      chk({nm, " m_be"}, 32'(m_be), 32'(ebe));
      chk({nm, " m_wdata"}, m_wdata, ewd);
    end
    chk({nm, " misalign"}, 32'(d_misalign), 32'(emis));
    chk({nm, " st done"}, 32'(d_done), 32'(we));
    chk({nm, " stall_m"}, 32'(stall_m), 32'(!we));
    @(negedge clk);
    m_ready = 1'b0;
    if (!we) begin
      for (int l = 1; l < lat; l++) begin
        #1;
        chk({nm, " wait done"}, 32'(d_done), 32'd0);
        chk({nm, " wait m_req"}, 32'(m_req), 32'd0);
        chk({nm, " wait mis"}, 32'(d_misalign), 32'd0);
        @(negedge clk);
      end
      m_rvalid = 1'b1; m_rdata = rd;
      #1;
      chk({nm, " ld done"}, 32'(d_done), 32'd1);
      chk({nm, " d_rdata"}, d_rdata, erd);
      chk({nm, " ld stall_m"}, 32'(stall_m), 32'd0);
      @(negedge clk);
      m_rvalid = 1'b0;
    end
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  f3;
    logic        we;
    logic [31:0] a, wd, rd, ewd, erd;
    logic [3:0]  ebe;
    logic        emis;
    int          dg;
    logic        got_i;

    tbl[0] = '{F3B(), 1'b1, 32'h2003, 32'h000000A5, 32'h0,
               4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0};
    tbl[1] = '{3'b010, 1'b1, 32'h2000, 32'hDEADBEEF, 32'h0,
               4'b1111, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[2] = '{3'b001, 1'b1, 32'h2002, 32'h00001234, 32'h0,
               4'b1100, 32'h12341234, 32'h0, 1'b0};
    tbl[3] = '{3'b000, 1'b0, 32'h2001, 32'h0, 32'h00008000,
               4'b0010, 32'h0, 32'hFFFFFF80, 1'b0};
    tbl[4] = '{3'b100, 1'b0, 32'h2001, 32'h0, 32'h00008000,
               4'b0010, 32'h0, 32'h00000080, 1'b0};
    tbl[5] = '{3'b010, 1'b0, 32'h2002, 32'h0, 32'hCAFEF00D,
               4'b1111, 32'h0, 32'hCAFEF00D, 1'b1};
    tbl[6] = '{3'b001, 1'b0, 32'h2002, 32'h0, 32'h80010000,
               4'b1100, 32'h0, 32'hFFFF8001, 1'b0};
    tbl[7] = '{3'b101, 1'b0, 32'h2003, 32'h0, 32'h80010000,
               4'b1100, 32'h0, 32'h00008001, 1'b1};

    rst_n = 1'b0; i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000;
    d_wdata = 32'h1; d_funct3 = 3'b010;
    m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
    #12;
    chk("rst m_req", 32'(m_req), 32'd0);
    chk("rst d_done", 32'(d_done), 32'd0);
    chk("rst stall_f", 32'(stall_f), 32'd0);
    chk("rst m_addr", m_addr, 32'd0);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // I-only fetch
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100; m_ready = 1'b1;
    #1;
    chk("if m_req", 32'(m_req), 32'd1);
    chk("if m_addr", m_addr, 32'h100);
    chk("if m_we", 32'(m_we), 32'd0);
    chk("if stall_f", 32'(stall_f), 32'd1);
    @(negedge clk);
    m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00500093;
    #1;
    chk("if rvalid", 32'(i_rvalid), 32'd1);
    chk("if rdata", i_rdata, 32'h00500093);
    chk("if stall_f done", 32'(stall_f), 32'd0);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("idle rvalid ignored", 32'(i_rvalid), 32'd0);
    chk("idle done ignored", 32'(d_done), 32'd0);
    @(negedge clk);
    m_rvalid = 1'b0;

    // contention: D store beats I, then I issues
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010;
    d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; m_ready = 1'b1;
    #1;
    chk("ct m_we", 32'(m_we), 32'd1);
    chk("ct m_be", 32'(m_be), 32'hF);
    chk("ct m_addr", m_addr, 32'h2000);
    chk("ct d_done", 32'(d_done), 32'd1);
    chk("ct stall_f", 32'(stall_f), 32'd1);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("ct i m_req", 32'(m_req), 32'd1);
    chk("ct i m_addr", m_addr, 32'h300);
    chk("ct i m_we", 32'(m_we), 32'd0);
    @(negedge clk);
    m_ready = 1'b0; d_req = 1'b1; d_addr = 32'h2004; d_wdata = 32'h1;
    #1;
    chk("ct wait m_req", 32'(m_req), 32'd0);
    chk("ct wait d_done", 32'(d_done), 32'd0);
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'h13;
    #1;
    chk("ct i rvalid", 32'(i_rvalid), 32'd1);
    chk("ct i rdata", i_rdata, 32'h13);
    @(negedge clk);
    i_req = 1'b0; m_rvalid = 1'b0; m_ready = 1'b1;
    #1;
    chk("ct late d m_req", 32'(m_req), 32'd1);
    chk("ct late d m_addr", m_addr, 32'h2004);
    chk("ct late d_done", 32'(d_done), 32'd1);
    @(negedge clk);
    d_req = 1'b0; m_ready = 1'b0;

    for (int t = 0; t < 8; t++)
      do_d($sformatf("vec%0d", t), tbl[t].f3, tbl[t].we, tbl[t].addr,
           tbl[t].wd, tbl[t].rd, t % 2, 1 + (t % 3), tbl[t].be,
           tbl[t].ewd, tbl[t].erd, tbl[t].mis);

    for (int r = 0; r < 40; r++) begin
      we = 1'($urandom_range(0, 1));
      case (we ? $urandom_range(0, 2) : $urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a  = $urandom;
      wd = $urandom;
      rd = $urandom;
      model(f3, a[1:0], wd, rd, ebe, ewd, erd, emis);
      do_d($sformatf("rnd%0d", r), f3, we, a, wd, rd,
           int'($urandom_range(0, 2)), int'($urandom_range(1, 3)),
           ebe, ewd, erd, emis);
    end

`ifdef ARB_STARVE_GUARD_EN
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010;
    d_addr = 32'h2000; m_ready = 1'b1;
    dg = 0; got_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (m_req && !m_we) begin got_i = 1'b1; break; end
      if (m_req && m_we) dg++;
      @(negedge clk);
    end
    chk("sv i granted", 32'(got_i), 32'd1);
    chk("sv d grants", 32'(dg), 32'd2);
    @(negedge clk);
    d_req = 1'b0; m_ready = 1'b0;
`else
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h600; m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
`endif
    // reset while I_WAIT: late rvalid must be dropped
    rst_n = 1'b0;
    #1;
    chk("rw m_req", 32'(m_req), 32'd0);
    chk("rw stall_f", 32'(stall_f), 32'd0);
    i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h77;
    #1;
    chk("rw late rvalid", 32'(i_rvalid), 32'd0);
    chk("rw late done", 32'(d_done), 32'd0);
    @(negedge clk);
    m_rvalid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic logic [2:0] F3B();
    return 3'b000;
  endfunction

endmodule
